mbist_mem_collar: RTL and testbench
===================================

// Module: mbist_mem_collar
// PURPOSE
//  Memory-side responder of the MBIST protocol: sits between one SRAM macro and its
//  functional master, and executes write / read-compare commands issued by the MBIST
//  controller. Muxes the SRAM port between functional and test traffic and compares
//  read data at fixed SRAM latency. Returns one in-order response per command and
//  keeps a sticky fail record: flag, first failing address and saturating count.
// PARAMETERS
//  ADDR_W   8   SRAM address width
//  DATA_W   32  SRAM data width
//  RD_LAT   1   SRAM read latency in cycles (>=1); mem_rdata valid RD_LAT cycles after mem_req
// PORTS
//  clk          in   1       clock
//  rst_n        in   1       asynchronous, active-low reset
//  test_en      in   1       1 = SRAM port owned by MBIST, 0 = functional
//  cmd_valid    in   1       controller command valid
//  cmd_ready    out  1       collar accepts command (= test_en)
//  cmd_op       in   2       mbist_op_e: 00 NOP, 01 WR, 10 RDC (read-compare), 11 CLR
//  cmd_addr     in   ADDR_W  target address
//  cmd_data     in   DATA_W  write data / expected read data
//  rsp_valid    out  1       one-cycle pulse per retired command
//  rsp_fail     out  1       retired RDC mismatched (0 for other ops)
//  fail_sticky  out  1       any mismatch since reset/CLR
//  fail_addr    out  ADDR_W  address of first mismatch since reset/CLR
//  fail_count   out  8       mismatch count, saturates at 8'hFF
//  fn_req/fn_we in   1/1     functional request / write enable
//  fn_addr      in   ADDR_W  functional address
//  fn_wdata     in   DATA_W  functional write data
//  fn_rdata     out  DATA_W  = mem_rdata (unmuxed)
//  mem_req/mem_we out 1/1    SRAM request / write enable
//  mem_addr     out  ADDR_W  SRAM address
//  mem_wdata    out  DATA_W  SRAM write data
//  mem_rdata    in   DATA_W  SRAM read data
// BEHAVIOUR
//  - Reset: all outputs and pipeline state 0; fail_sticky=0, fail_addr=0, fail_count=0.
//  - Accept: cmd_valid && cmd_ready in cycle N. No backpressure beyond test_en; one cmd/cycle.
//  - SRAM mux (combinational): test_en=1 -> mem_req=accept&&(op==WR||op==RDC), mem_we=(op==WR),
//    addr/wdata from cmd; test_en=0 -> fn_* passed through. NOP/CLR never touch SRAM.
//  - Pipeline: every accepted cmd (incl. NOP/CLR) enters a RD_LAT-deep delay line carrying
//    {op, addr, exp}. At stage RD_LAT (cycle N+RD_LAT) RDC compares mem_rdata vs exp.
//    Results are registered: rsp_valid/rsp_fail assert in cycle N+RD_LAT+1. Fixed latency,
//    strictly in order.
//  - Fail record (updated at retire, same edge as rsp_valid): on RDC mismatch set fail_sticky;
//    if fail_sticky was 0, capture fail_addr; fail_count+1, holding at 8'hFF.
//  - CLR clears fail_sticky/addr/count when it retires; mismatches from commands accepted
//    before CLR are recorded first (in-order retire, one per cycle -> no same-cycle conflict).
//  - test_en falling mid-operation: cmd_ready drops immediately, in-flight commands still drain
//    and respond; functional traffic may use the SRAM from the same cycle (responses are
//    tracked by pipeline position, never by mem_rdata ownership).
//  - test_en rising: first command may be accepted in the same cycle; functional req ignored.
//  - Async reset mid-operation: pipeline flushed, no response for in-flight commands.
// STRUCTURE
//  - mbist_pkg: typedef enum logic [1:0] mbist_op_e {NOP,WR,RDC,CLR}; FAIL_CNT_W=8.
//  - Sub-module mbist_rd_pipe: parameterized RD_LAT-stage valid/op/addr/exp delay line.
//  - Top: SRAM mux, compare/retire register, fail record.
// TESTING
//  1 RD_LAT=1: WR 0x05<=A5A5A5A5, RDC 0x05 exp A5A5A5A5 -> two rsp pulses at N+2, N+3, rsp_fail=0.
//  2 Model returns bit-flipped data at 0x10 and 0x20: RDC both -> fail_sticky=1,
//    fail_addr=0x10, fail_count=2.
//  3 Back-to-back RDC mismatch then CLR -> fail_count=1 recorded, then cleared to 0 on CLR retire.
//  4 300 consecutive mismatching RDCs -> fail_count holds 8'hFF, fail_addr = first address.
//  5 RD_LAT=3: 4 back-to-back cmds -> rsp_valid at N+4..N+7, in order; test_en drop after
//    issue -> all 4 responses still produced, fn_req reaches mem_req in the drop cycle.
//  6 Assert rst_n low with 2 RDCs in flight -> no rsp_valid afterwards, all outputs 0.

Source files
------------

// File: rtl/mbist_pkg.sv
// Shared MBIST definitions: the command opcode set used between the controller
// and the memory collar, and the width of the saturating fail counter.
package mbist_pkg;

   typedef enum logic [1:0] {
      NOP = 2'b00,
      WR  = 2'b01,
      RDC = 2'b10,
      CLR = 2'b11
   } mbist_op_e;

   localparam int FAIL_CNT_W = 8;

endpackage

// File: rtl/mbist_rd_pipe.sv
// RD_LAT-stage delay line that tracks accepted commands while the SRAM read is
// in flight. The last stage lines up with mem_rdata of the command's request.
// Ports:
//   clk, rst_n            clock, async active-low reset (flushes every stage)
//   in_valid/op/addr/exp  command entering stage 1
//   out_valid/op/addr/exp command at stage RD_LAT
module mbist_rd_pipe
   import mbist_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  mbist_op_e         in_op,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_exp,
   output logic              out_valid,
   output mbist_op_e         out_op,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_exp
);

   logic [RD_LAT-1:0] vld_q;
   mbist_op_e         op_q   [RD_LAT];
   logic [ADDR_W-1:0] addr_q [RD_LAT];
   logic [DATA_W-1:0] exp_q  [RD_LAT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            op_q[i]   <= NOP;
            addr_q[i] <= '0;
            exp_q[i]  <= '0;
         end
      end else begin
         vld_q[0]  <= in_valid;
         op_q[0]   <= in_op;
         addr_q[0] <= in_addr;
         exp_q[0]  <= in_exp;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_q[i]  <= vld_q[i-1];
            op_q[i]   <= op_q[i-1];
            addr_q[i] <= addr_q[i-1];
            exp_q[i]  <= exp_q[i-1];
         end
      end
   end

   assign out_valid = vld_q[RD_LAT-1];
   assign out_op    = op_q[RD_LAT-1];
   assign out_addr  = addr_q[RD_LAT-1];
   assign out_exp   = exp_q[RD_LAT-1];

endmodule

// File: rtl/mbist_mem_collar.sv
// Memory-side MBIST responder for one SRAM macro. Muxes the SRAM port between
// functional and test traffic, retires every accepted command in order at a
// fixed latency of RD_LAT+1 cycles, and keeps a sticky fail record.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   test_en                           1 = SRAM owned by MBIST
//   cmd_valid/ready/op/addr/data      controller command (ready = test_en)
//   rsp_valid, rsp_fail               one-cycle response per retired command
//   fail_sticky/addr/count            fail record, cleared by reset or CLR
//   fn_req/we/addr/wdata, fn_rdata    functional master port
//   mem_req/we/addr/wdata, mem_rdata  SRAM port
module mbist_mem_collar
   import mbist_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  test_en,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [ADDR_W-1:0]     cmd_addr,
   input  logic [DATA_W-1:0]     cmd_data,
   output logic                  rsp_valid,
   output logic                  rsp_fail,
   output logic                  fail_sticky,
   output logic [ADDR_W-1:0]     fail_addr,
   output logic [FAIL_CNT_W-1:0] fail_count,
   input  logic                  fn_req,
   input  logic                  fn_we,
   input  logic [ADDR_W-1:0]     fn_addr,
   input  logic [DATA_W-1:0]     fn_wdata,
   output logic [DATA_W-1:0]     fn_rdata,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W-1:0]     mem_rdata
);

   mbist_op_e         op;
   logic              accept;
   logic              ret_valid;
   mbist_op_e         ret_op;
   logic [ADDR_W-1:0] ret_addr;
   logic [DATA_W-1:0] ret_exp;
   logic              mismatch;

   assign op        = mbist_op_e'(cmd_op);
   assign cmd_ready = test_en;
   assign accept    = cmd_valid && test_en;
   assign fn_rdata  = mem_rdata;

   always_comb begin
      if (test_en) begin
         mem_req   = accept && (op == WR || op == RDC);
         mem_we    = accept && (op == WR);
         mem_addr  = cmd_addr;
         mem_wdata = cmd_data;
      end else begin
         mem_req   = fn_req;
         mem_we    = fn_we;
         mem_addr  = fn_addr;
         mem_wdata = fn_wdata;
      end
   end

   // NOP/CLR ride the pipe too so every command retires at the same latency
   // and CLR cannot overtake mismatches still in flight.
   mbist_rd_pipe #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT)
   ) u_rd_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (accept),
      .in_op     (op),
      .in_addr   (cmd_addr),
      .in_exp    (cmd_data),
      .out_valid (ret_valid),
      .out_op    (ret_op),
      .out_addr  (ret_addr),
      .out_exp   (ret_exp)
   );

   assign mismatch = ret_valid && (ret_op == RDC) && (mem_rdata != ret_exp);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid   <= 1'b0;
         rsp_fail    <= 1'b0;
         fail_sticky <= 1'b0;
         fail_addr   <= '0;
         fail_count  <= '0;
      end else begin
         rsp_valid <= ret_valid;
         rsp_fail  <= mismatch;
         if (ret_valid && ret_op == CLR) begin
            fail_sticky <= 1'b0;
            fail_addr   <= '0;
            fail_count  <= '0;
         end else if (mismatch) begin
            fail_sticky <= 1'b1;
            if (!fail_sticky)
               fail_addr <= ret_addr;
            if (fail_count != '1)
               fail_count <= fail_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mbist_mem_collar.sv
// Bench for mbist_mem_collar: one collar at RD_LAT=1 and one at RD_LAT=3 see
// the same command stream, each with its own SRAM model. Expected responses
// and fail-record values are queued at issue and checked at retire.
module tb_mbist_mem_collar;
   import mbist_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        test_en = 1'b0, cmd_valid = 1'b0, fn_req = 1'b0, fn_we = 1'b0;
   logic [1:0]  cmd_op = 2'b00;
   logic [7:0]  cmd_addr = '0, fn_addr = '0;
   logic [31:0] cmd_data = '0, fn_wdata = '0;

   logic        cmd_ready1, rsp_valid1, rsp_fail1, fail_sticky1, mem_req1, mem_we1;
   logic [7:0]  fail_addr1, fail_count1, mem_addr1;
   logic [31:0] fn_rdata1, mem_wdata1, mem_rdata1;
   logic        cmd_ready3, rsp_valid3, rsp_fail3, fail_sticky3, mem_req3, mem_we3;
   logic [7:0]  fail_addr3, fail_count3, mem_addr3;
   logic [31:0] fn_rdata3, mem_wdata3, mem_rdata3;

   mbist_mem_collar #(.ADDR_W(8), .DATA_W(32), .RD_LAT(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .test_en(test_en), .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready1), .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid1), .rsp_fail(rsp_fail1), .fail_sticky(fail_sticky1),
      .fail_addr(fail_addr1), .fail_count(fail_count1), .fn_req(fn_req), .fn_we(fn_we),
      .fn_addr(fn_addr), .fn_wdata(fn_wdata), .fn_rdata(fn_rdata1), .mem_req(mem_req1),
      .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1));

   mbist_mem_collar #(.ADDR_W(8), .DATA_W(32), .RD_LAT(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .test_en(test_en), .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready3), .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid3), .rsp_fail(rsp_fail3), .fail_sticky(fail_sticky3),
      .fail_addr(fail_addr3), .fail_count(fail_count3), .fn_req(fn_req), .fn_we(fn_we),
      .fn_addr(fn_addr), .fn_wdata(fn_wdata), .fn_rdata(fn_rdata3), .mem_req(mem_req3),
      .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3));

   // SRAM models: addresses 0x10 and 0x20 read back with bit 0 flipped.
   function automatic logic [31:0] flip(input logic [7:0] a);
      return (a == 8'h10 || a == 8'h20) ? 32'h1 : 32'h0;
   endfunction

   logic [31:0] m1 [256];
   logic [31:0] m3 [256];
   logic [31:0] ref_mem [256];
   logic [31:0] rd1;
   logic [31:0] p3 [3];
   assign mem_rdata1 = rd1;
   assign mem_rdata3 = p3[2];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (mem_req1) begin
         if (mem_we1) m1[mem_addr1] <= mem_wdata1;
         rd1 <= m1[mem_addr1] ^ flip(mem_addr1);
      end
      if (mem_req3) begin
         if (mem_we3) m3[mem_addr3] <= mem_wdata3;
         p3[0] <= m3[mem_addr3] ^ flip(mem_addr3);
      end
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end

   int vecs = 0;
   int errs = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   typedef struct {
      mbist_op_e  op;
      logic [7:0] addr;
      logic       fail;
      int         due;
   } exp_t;

   exp_t       sb [2][$];
   logic       es [2];
   logic [7:0] ea [2];
   logic [7:0] ec [2];

   task automatic clear_model();
      for (int k = 0; k < 2; k++) begin
         sb[k].delete();
         es[k] = 1'b0;
         ea[k] = '0;
         ec[k] = '0;
      end
   endtask

   task automatic mon(input int k, input logic rv, input logic rf, input logic fs,
                      input logic [7:0] fa, input logic [7:0] fc);
      exp_t e;
      if (rv) begin
         if (sb[k].size() == 0) begin
            chk("rsp_extra", {31'b0, rv}, 32'd0);
         end else begin
            e = sb[k].pop_front();
            chk("rsp_cycle", cyc, e.due);
            chk("rsp_fail", {31'b0, rf}, {31'b0, e.fail});
            if (e.op == CLR) begin
               es[k] = 1'b0; ea[k] = '0; ec[k] = '0;
            end else if (e.fail) begin
               if (!es[k]) ea[k] = e.addr;
               es[k] = 1'b1;
               if (ec[k] != 8'hFF) ec[k] = ec[k] + 8'd1;
            end
            chk("fail_sticky", {31'b0, fs}, {31'b0, es[k]});
            chk("fail_addr", {24'b0, fa}, {24'b0, ea[k]});
            chk("fail_count", {24'b0, fc}, {24'b0, ec[k]});
         end
      end else if (sb[k].size() != 0 && sb[k][0].due <= cyc) begin
         chk("rsp_valid", {31'b0, rv}, 32'd1);
         void'(sb[k].pop_front());
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         mon(0, rsp_valid1, rsp_fail1, fail_sticky1, fail_addr1, fail_count1);
         mon(1, rsp_valid3, rsp_fail3, fail_sticky3, fail_addr3, fail_count3);
      end
   end

   task automatic send(input mbist_op_e op, input logic [7:0] a, input logic [31:0] d);
      logic fl;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = a;
      cmd_data  = d;
      if (test_en) begin
         fl = (op == RDC) && (d != (ref_mem[a] ^ flip(a)));
         sb[0].push_back('{op: op, addr: a, fail: fl, due: cyc + 2});
         sb[1].push_back('{op: op, addr: a, fail: fl, due: cyc + 4});
         if (op == WR) ref_mem[a] = d;
      end
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_rsp1"}, {31'b0, rsp_valid1}, 32'd0);
      chk({tag, "_sticky1"}, {31'b0, fail_sticky1}, 32'd0);
      chk({tag, "_addr1"}, {24'b0, fail_addr1}, 32'd0);
      chk({tag, "_cnt1"}, {24'b0, fail_count1}, 32'd0);
      chk({tag, "_rsp3"}, {31'b0, rsp_valid3}, 32'd0);
      chk({tag, "_cnt3"}, {24'b0, fail_count3}, 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) begin
         m1[i] = '0; m3[i] = '0; ref_mem[i] = '0;
      end
      rd1 = '0;
      for (int i = 0; i < 3; i++) p3[i] = '0;
      clear_model();

      #12;
      chk_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_en = 1'b1;
      #1;
      chk("cmd_ready", {31'b0, cmd_ready1}, 32'd1);

      // 1: write then read-compare, no mismatch
      send(WR, 8'h05, 32'hA5A5_A5A5);
      send(RDC, 8'h05, 32'hA5A5_A5A5);
      idle(6);

      // 2: flipped bits at 0x10 and 0x20
      send(WR, 8'h10, 32'h1234_5678);
      send(WR, 8'h20, 32'h9ABC_DEF0);
      send(RDC, 8'h10, 32'h1234_5678);
      send(RDC, 8'h20, 32'h9ABC_DEF0);
      idle(6);
      chk("t2_sticky", {31'b0, fail_sticky1}, 32'd1);
      chk("t2_addr", {24'b0, fail_addr1}, 32'h10);
      chk("t2_cnt", {24'b0, fail_count1}, 32'd2);
      chk("t2_cnt3", {24'b0, fail_count3}, 32'd2);

      // 3: clear, then mismatch immediately followed by CLR
      send(CLR, 8'h00, 32'h0);
      idle(6);
      send(RDC, 8'h05, 32'h0000_0000);
      send(CLR, 8'h00, 32'h0);
      idle(6);
      chk("t3_cnt", {24'b0, fail_count1}, 32'd0);
      chk("t3_sticky3", {31'b0, fail_sticky3}, 32'd0);

      // 4: 300 mismatching reads, counter saturates, first address held
      for (int i = 0; i < 300; i++) begin
         logic [7:0] a;
         a = 8'(i + 3);
         send(RDC, a, ~(ref_mem[a] ^ flip(a)));
      end
      idle(6);
      chk("t4_cnt", {24'b0, fail_count1}, 32'hFF);
      chk("t4_addr", {24'b0, fail_addr1}, 32'h03);
      chk("t4_cnt3", {24'b0, fail_count3}, 32'hFF);
      send(CLR, 8'h00, 32'h0);
      idle(6);

      // 5: four back-to-back commands, then test_en drops with commands in flight
      send(WR, 8'h40, 32'hCAFE_0001);
      send(RDC, 8'h40, 32'hCAFE_0001);
      send(RDC, 8'h10, 32'h0000_0000);
      send(NOP, 8'h00, 32'h0);
      @(negedge clk);
      test_en  = 1'b0;
      fn_req   = 1'b1;
      fn_we    = 1'b0;
      fn_addr  = 8'h77;
      #1;
      chk("drop_ready", {31'b0, cmd_ready3}, 32'd0);
      chk("drop_req", {31'b0, mem_req3}, 32'd1);
      chk("drop_addr", {24'b0, mem_addr3}, 32'h77);
      chk("drop_we", {31'b0, mem_we3}, 32'd0);
      chk("drop_req1", {31'b0, mem_req1}, 32'd1);
      cmd_valid = 1'b0;
      idle(6);
      chk("fn_rdata", fn_rdata3, mem_rdata3);
      @(negedge clk);
      test_en = 1'b1;
      #1;
      chk("fn_ignored", {31'b0, mem_req1}, 32'd0);
      fn_req = 1'b0;

      // 6: reset with two reads in flight
      send(RDC, 8'h10, 32'h0);
      send(RDC, 8'h20, 32'h0);
      @(negedge clk);
      cmd_valid = 1'b0;
      rst_n = 1'b0;
      clear_model();
      #1;
      chk_zero("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      chk_zero("postrst");

      chk("drain", sb[0].size() + sb[1].size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
